// File: rtl/seq_muldiv_unit.sv
// ---------------------------------------------------------------------------
// seq_muldiv_unit
//
// Iterative unsigned multiply / divide execution stage. Takes two operands read
// from the 4x8 register file, runs WIDTH shift-add (multiply) or restoring
// shift-subtract (divide) steps, then drives the register file write port to
// write the low result back to dest_addr.
//
// Optional feature, macro MULDIV_HI_WB_EN:
//   defined   -> an extra WB_HI cycle writes result_hi to (dest_addr+1) mod 4;
//                done pulses in WB_HI instead of WB.
//   undefined -> single write-back cycle; the high byte / remainder is only
//                visible on result_hi.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              request, accepted only while idle (busy=0)
//   op                 0 = multiply, 1 = divide (both unsigned)
//   operand_a/b        multiplicand/multiplier or dividend/divisor
//   dest_addr          destination register
//   busy               operation in flight (RUN and all write-back cycles)
//   done               one-cycle pulse on the final write-back cycle
//   div_by_zero        valid with done
//   result_hi          product high half / remainder, valid with done
//   RegWrite           register-file write enable
//   write_addr/data    register-file write address / data
//   dbg_state          current FSM state, for checkers
//
// Handshake: start is sampled on a rising edge while the unit is idle; it is
// a request, not a valid/ready pair, so a start seen while busy is dropped and
// never queued. Completion is signalled only by done (no back-pressure).
//
// Timing: start accepted at edge E0. RUN performs WIDTH steps on edges
// E0+1..E0+WIDTH, then holds the finished result for one more cycle while the
// write-back registers are loaded; all outputs are registered, so RegWrite is
// high in the cycle after edge E0+WIDTH+1.
// ---------------------------------------------------------------------------
module seq_muldiv_unit #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [WIDTH-1:0]  result_hi,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_addr,
  output logic [WIDTH-1:0]  write_data,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WB    = 2'd2
`ifdef MULDIV_HI_WB_EN
    ,
    ST_WB_HI = 2'd3
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               op_q, op_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // hi/lo: product {hi,lo} for multiply; remainder (hi) and quotient (lo,
  // shifting in from the dividend) for divide.
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]  write_addr_q, write_addr_d;
  logic [WIDTH-1:0]   write_data_q, write_data_d;

  // Single iteration datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    // The true difference is always below the divisor when rem_ge is set,
    // so WIDTH bits are enough. A zero divisor makes every step "fit",
    // yielding an all-ones quotient and the dividend as remainder.
    rem_diff  = rem_shift[WIDTH-1:0] - opnd_q;
    rem_ge    = (rem_shift >= {1'b0, opnd_q});
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    op_d         = op_q;
    opnd_d       = opnd_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    dest_d       = dest_q;
    done_d       = 1'b0;
    dbz_d        = dbz_q;
    result_hi_d  = result_hi_q;
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d        = op;
          opnd_d      = op ? operand_b : operand_a;
          hi_d        = '0;
          lo_d        = op ? operand_a : operand_b;
          dest_d      = dest_addr;
          count_d     = '0;
          dbz_d       = 1'b0;
          result_hi_d = '0;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (count_q != CNT_W'(WIDTH)) begin
          if (op_q) begin
            hi_d = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], rem_ge};
          end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          count_d = count_q + CNT_W'(1);
        end else begin
          // Result is final; load the write-back registers.
          state_d      = ST_WB;
          reg_write_d  = 1'b1;
          write_addr_d = dest_q;
          write_data_d = lo_q;
          result_hi_d  = hi_q;
          dbz_d        = op_q && (opnd_q == '0);
`ifdef MULDIV_HI_WB_EN
          done_d       = 1'b0;
`else
          done_d       = 1'b1;
`endif
        end
      end

      ST_WB: begin
`ifdef MULDIV_HI_WB_EN
        state_d      = ST_WB_HI;
        reg_write_d  = 1'b1;
        write_addr_d = dest_q + ADDR_W'(1);
        write_data_d = hi_q;
        done_d       = 1'b1;
`else
        state_d      = ST_IDLE;
`endif
      end

`ifdef MULDIV_HI_WB_EN
      ST_WB_HI: begin
        state_d = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      op_q         <= 1'b0;
      opnd_q       <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      dest_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dbz_q        <= 1'b0;
      result_hi_q  <= '0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      op_q         <= op_d;
      opnd_q       <= opnd_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      dest_q       <= dest_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dbz_q        <= dbz_d;
      result_hi_q  <= result_hi_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign result_hi   = result_hi_q;
  assign RegWrite    = reg_write_q;
  assign write_addr  = write_addr_q;
  assign write_data  = write_data_q;
  assign dbg_state   = state_q;

endmodule
